stopwatch_bcd_core: RTL
=======================

// Module: stopwatch_bcd_core
// PURPOSE
//  Stopwatch timebase and state machine, upstream of the 7-segment display stage.
//  Conditions the raw start/stop buttons and counts SS.cc (00.00-99.99) in BCD.
//  Outputs four BCD digits: seconds go to the seg_ab display pair, centiseconds to seg_cd.
//  Runs on the 125 MHz board clock.
// PARAMETERS
//  CLK_HZ   125_000_000  input clock frequency
//  TICK_HZ  100          count rate (centiseconds); TICK_DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
//  DEB_CNT  1_250_000    consecutive stable cycles required to accept a button change (10 ms)
// PORTS
//  clk      in   1   system clock, rising edge
//  rst      in   1   asynchronous reset, active-high
//  start    in   1   raw start button, asynchronous, active-high
//  stop     in   1   raw stop/clear button, asynchronous, active-high
//  bcd      out  16  {sec_tens, sec_ones, cs_tens, cs_ones}, 4 bits each, every nibble 0-9
//  running  out  1   1 while in RUN
//  wrap     out  1   one-cycle pulse when the count rolls 99.99 -> 00.00
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE, bcd=16'h0000, running=0, wrap=0.
//   - prescaler, sync flops, debounce counters and debounced levels all cleared.
//  Button conditioning (per button):
//   - 2-FF synchronizer.
//   - Debounced level changes only after the synced level differs from it for DEB_CNT consecutive cycles.
//   - Registered rising-edge detect gives a 1-cycle pulse: start_p / stop_p.
//   - Latency: input high at edge k -> pulse high in cycle k+DEB_CNT+3.
//   - Releasing the button produces no pulse. A hold produces exactly one pulse.
//  FSM (states IDLE, RUN, PAUSE; transitions evaluated on the pulse cycle, effective next edge):
//   - IDLE  + start_p -> RUN; prescaler starts from 0.
//   - RUN   + stop_p  -> PAUSE; prescaler and digits hold.
//   - PAUSE + start_p -> RUN; prescaler resumes from its held value.
//   - PAUSE + stop_p  -> IDLE; bcd=0 and prescaler=0 on the same edge.
//   - start_p and stop_p in the same cycle: stop_p wins, start_p is ignored.
//   - Any other pulse has no effect: start in RUN, stop in IDLE.
//  Timebase:
//   - Prescaler counts 0..TICK_DIV-1 only in RUN.
//   - tick fires on terminal count; prescaler wraps to 0 on the same edge.
//  BCD count (on tick):
//   - cs_ones increments; at 9 -> 0 with carry into cs_tens.
//   - Carries ripple cs_tens -> sec_ones -> sec_tens on the same edge.
//   - At 99.99 all digits -> 0, and wrap=1 for exactly that cycle. Counting continues in RUN.
//  General:
//   - bcd is registered; it updates on the tick edge with no extra latency.
//   - running is a registered decode of state.
//   - A tick in the same cycle as stop_p in RUN is still counted; the pause applies from the next edge.
//   - Reset asserted mid-count returns to IDLE/00.00 immediately, with no pending pulse after release.
//   - bcd never holds a nibble > 9.
// STRUCTURE
//  Shared header stopwatch_defs.vh:
//   - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
//   - BCD_MAX=4'd9.
//   - default CLK_HZ and TICK_HZ.
//  Sub-module btn_cond (synchronizer + debounce + edge pulse, parameter DEB_CNT), instantiated twice.
//  The prescaler, FSM and BCD chain stay in this module.
// TESTING  (bench overrides CLK_HZ=1000, TICK_HZ=100 -> TICK_DIV=10; DEB_CNT=2; 125 MHz clock, #4 toggle)
//  1 Reset:
//     rst=1 for 3 ns with start=1 -> bcd=0000, running=0.
//     Release; start held -> running=1 exactly DEB_CNT+3 cycles after the first sampling edge.
//  2 Count:
//     RUN for 1000 cycles -> bcd=16'h0100 (01.00).
//     Check the 09->10 and 99->100 centisecond carries at their exact tick cycles.
//  3 Pause/resume:
//     stop pulse at bcd=0012 -> value frozen for 500 cycles.
//     start -> next increment after the remaining prescaler cycles, not a full TICK_DIV.
//  4 Clear:
//     stop again in PAUSE -> bcd=0000, running=0.
//     A start pulse while in RUN has no effect.
//  5 Wrap:
//     Run to 99.99; the next tick gives bcd=0000 with wrap high for exactly 1 cycle.
//     running stays 1.
//  6 Bounce/simultaneity:
//     A 1-cycle glitch on start produces no pulse.
//     start and stop asserted together in RUN -> PAUSE.
//     rst during RUN -> immediate 0000/IDLE.

Source files
------------

// File: rtl/stopwatch_bcd_core_pkg.sv
// Purpose: shared types, encodings and helpers for the stopwatch BCD core.
// Latency: n/a (package only).
// Backpressure: n/a.
package stopwatch_bcd_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int DEF_CLK_HZ  = 125_000_000;
  localparam int DEF_TICK_HZ = 100;
  localparam int DEF_DEB_CNT = 1_250_000;  // 10 ms at 125 MHz

  // SS.cc, most significant digit first
  typedef struct packed {
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] cs_tens;
    logic [3:0] cs_ones;
  } bcd_t;

  typedef struct packed {
    logic       carry;
    logic [3:0] digit;
  } digit_inc_t;

  // One BCD digit stage of the ripple chain. ">=" folds any out-of-range
  // nibble back to 0 so the counter can never sit above 9.
  function automatic digit_inc_t bcd_inc(input logic [3:0] d, input logic cin);
    digit_inc_t r;
    r.carry = 1'b0;
    r.digit = d;
    if (cin) begin
      if (d >= BCD_MAX) begin
        r.carry = 1'b1;
        r.digit = 4'd0;
      end else begin
        r.digit = d + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_core_if.sv
// Purpose: button inputs and BCD/status outputs of the stopwatch core.
// Latency: n/a (wiring only).
// Backpressure: none; buttons are raw levels, outputs are free-running.
// Ports: start/stop raw buttons (master drives); bcd {ss,cc} digits, running
//        level and wrap pulse (slave drives).
interface stopwatch_bcd_core_if;
  logic        start;
  logic        stop;
  logic [15:0] bcd;
  logic        running;
  logic        wrap;

  modport master (output start, output stop, input bcd, input running, input wrap);
  modport slave  (input start, input stop, output bcd, output running, output wrap);
endinterface

// File: rtl/stopwatch_bcd_core_btn_cond.sv
// Purpose: condition one raw button: 2-FF sync, debounce, rising-edge pulse.
// Latency: button high at edge k -> pulse high in cycle k+DEB_CNT+3.
// Backpressure: none; pulse is a single-cycle event, release gives no pulse.
// Ports: clk, rst (async, active-high), btn raw input, pulse 1-cycle output.
module stopwatch_bcd_core_btn_cond #(
  parameter int DEB_CNT = 1_250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_q <= deb;
      pulse <= deb & ~deb_q;
      // cnt is the length of the current run of samples disagreeing with
      // deb; any agreeing sample restarts the qualification window.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_bcd_core.sv
// Purpose: stopwatch FSM, centisecond prescaler and SS.cc BCD counter.
// Latency: bcd/running/wrap registered; button effect DEB_CNT+4 edges after press.
// Backpressure: none; counts whenever in RUN.
// Ports: clk, rst (async, active-high), sw slave modport (start/stop in,
//        bcd/running/wrap out).
module stopwatch_bcd_core
  import stopwatch_bcd_core_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ,
  parameter int DEB_CNT = DEF_DEB_CNT
) (
  input  logic                 clk,
  input  logic                 rst,
  stopwatch_bcd_core_if.slave  sw
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          start_p;
  logic          stop_p;
  sw_state_e     state;
  sw_state_e     state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  bcd_t          cnt_q;
  bcd_t          cnt_nxt;
  logic          tick;
  logic          wrap_nxt;
  logic          running_q;
  logic          wrap_q;
  digit_inc_t    inc_cs_ones;
  digit_inc_t    inc_cs_tens;
  digit_inc_t    inc_sec_ones;
  digit_inc_t    inc_sec_tens;

  stopwatch_bcd_core_btn_cond #(.DEB_CNT(DEB_CNT)) u_start_cond (
    .clk   (clk),
    .rst   (rst),
    .btn   (sw.start),
    .pulse (start_p)
  );

  stopwatch_bcd_core_btn_cond #(.DEB_CNT(DEB_CNT)) u_stop_cond (
    .clk   (clk),
    .rst   (rst),
    .btn   (sw.stop),
    .pulse (stop_p)
  );

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    tick      = 1'b0;

    // The prescaler advances on every RUN cycle, including the one where
    // stop_p arrives: the pause only takes hold from the next edge.
    if (state == ST_RUN) begin
      tick      = (presc == PRESC_LAST);
      presc_nxt = tick ? '0 : presc + PW'(1);
    end

    inc_cs_ones  = bcd_inc(cnt_q.cs_ones,  tick);
    inc_cs_tens  = bcd_inc(cnt_q.cs_tens,  inc_cs_ones.carry);
    inc_sec_ones = bcd_inc(cnt_q.sec_ones, inc_cs_tens.carry);
    inc_sec_tens = bcd_inc(cnt_q.sec_tens, inc_sec_ones.carry);

    cnt_nxt.cs_ones  = inc_cs_ones.digit;
    cnt_nxt.cs_tens  = inc_cs_tens.digit;
    cnt_nxt.sec_ones = inc_sec_ones.digit;
    cnt_nxt.sec_tens = inc_sec_tens.digit;
    wrap_nxt         = inc_sec_tens.carry;

    // stop_p is tested first everywhere so it wins over a coincident start_p.
    case (state)
      ST_IDLE: begin
        if (!stop_p && start_p) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop_p) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop_p) begin
          state_nxt = ST_IDLE;
          presc_nxt = '0;
          cnt_nxt   = '0;
        end else if (start_p) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        presc_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      presc     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      cnt_q     <= cnt_nxt;
      running_q <= (state_nxt == ST_RUN);
      wrap_q    <= wrap_nxt;
    end
  end

  assign sw.bcd     = cnt_q;
  assign sw.running = running_q;
  assign sw.wrap    = wrap_q;

endmodule
